// File: rtl/coax_rx_controller.sv
// -----------------------------------------------------------------------------
// coax_rx_controller
//
// Sequences one coax_rx receiver. Each received word is drained through the
// receiver's read handshake, the receiver is recovered from its sticky ERROR
// state by pulsing its reset, and frame boundaries are tagged. Words are handed
// to the host side through a show-ahead FIFO whose entries are
// {err, eof, data[9:0]}.
//
// Optional feature (compile-time macro):
//   COAX_RX_CONTROLLER_FRAME_LENGTH_EN
//     Adds output frame_length[9:0]: number of words in the most recently
//     completed frame (saturating at 1023). Undefined: no port, no counter.
//
// Parameters:
//   DEPTH         FIFO entries, power of 2, >= 2
//   RESET_CYCLES  cycles rx_reset is held high during error recovery, >= 1
//
// Ports:
//   clk                in   system clock
//   reset              in   synchronous, active-low
//   enable             in   1 = receive, 0 = receiver held in reset
//   rx_reset           out  reset to coax_rx
//   rx_active          in   coax_rx active (falling edge = end of frame)
//   rx_error           in   coax_rx sticky error
//   rx_data[9:0]       in   coax_rx word, or error code while rx_error
//   rx_data_available  in   coax_rx word ready
//   rx_read            out  coax_rx read strobe
//   fifo_data[11:0]    out  FIFO head {err, eof, data}, valid while !fifo_empty
//   fifo_read          in   pop head (ignored when empty)
//   fifo_empty         out  FIFO empty
//   fifo_full          out  FIFO holds DEPTH entries
//   overflow           out  sticky: an entry was dropped on a full FIFO
//   last_error[9:0]    out  code of the most recent receiver error
//   clear_status       in   clears overflow and last_error
//   frame_length[9:0]  out  (macro only) length of last completed frame
//
// Receiver handshake: when rx_data_available is seen in IDLE the word is
// captured and rx_read is pulsed high for exactly one cycle. coax_rx drops
// rx_data_available on the falling edge of rx_read; the controller then waits
// until rx_data_available is observed low before it may capture again, so a
// single word can never be captured twice.
// -----------------------------------------------------------------------------
module coax_rx_controller #(
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rx_reset,
    input  logic        rx_active,
    input  logic        rx_error,
    input  logic [9:0]  rx_data,
    input  logic        rx_data_available,
    output logic        rx_read,
    output logic [11:0] fifo_data,
    input  logic        fifo_read,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow,
    output logic [9:0]  last_error,
    input  logic        clear_status
`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
    ,
    output logic [9:0]  frame_length
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_DISABLED   = 3'd0,
        S_IDLE       = 3'd1,
        S_READ_HI    = 3'd2,
        S_READ_LO    = 3'd3,
        S_WAIT_CLEAR = 3'd4,
        S_ERROR      = 3'd5,
        S_RECOVER    = 3'd6
    } state_t;

    state_t state;
    state_t next_state;

    // Error-recovery reset timer
    logic [RCW-1:0] rst_cnt;
    logic           rst_done;

    // Per-cycle actions decoded from the FSM
    logic rx_reset_d;
    logic rx_read_d;
    logic do_capture;
    logic do_eof;
    logic do_error;

    // One-word holdback and frame-end tracking
    logic [9:0] hold;
    logic       hold_valid;
    logic       eof_pending;
    logic       rx_active_q;
    logic       eof_fall;

    // FIFO
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_n;
    logic          push;
    logic [11:0]   push_data;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [11:0]   head_n;

    assign rst_done = (rst_cnt == RCW'(RESET_CYCLES - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_DISABLED;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = S_DISABLED;
        end else begin
            case (state)
                S_DISABLED:   next_state = S_IDLE;
                S_IDLE: begin
                    if (rx_error)               next_state = S_ERROR;
                    else if (rx_data_available) next_state = S_READ_HI;
                end
                S_READ_HI:    next_state = S_READ_LO;
                S_READ_LO:    next_state = S_WAIT_CLEAR;
                S_WAIT_CLEAR: begin
                    if (rx_error)                next_state = S_ERROR;
                    else if (!rx_data_available) next_state = S_IDLE;
                end
                S_ERROR: begin
                    if (rst_done) next_state = S_RECOVER;
                end
                S_RECOVER: begin
                    if (!rx_error) next_state = S_IDLE;
                end
                default:      next_state = S_DISABLED;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / action decode
    // rx_reset and rx_read are derived from next_state and registered, so the
    // registered outputs line up exactly with the state they belong to.
    // -------------------------------------------------------------------------
    always_comb begin
        rx_reset_d = (next_state == S_DISABLED) || (next_state == S_ERROR);
        rx_read_d  = (next_state == S_READ_HI);
        do_capture = 1'b0;
        do_eof     = 1'b0;
        do_error   = 1'b0;
        if (enable) begin
            if ((state == S_IDLE || state == S_WAIT_CLEAR) && rx_error) begin
                do_error = 1'b1;
            end else if (state == S_IDLE) begin
                // End-of-frame waits until no word is mid-handshake, so the
                // last word of a frame is always the one that gets tagged.
                do_capture = rx_data_available;
                do_eof     = !rx_data_available && eof_pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_reset <= 1'b1;
            rx_read  <= 1'b0;
        end else begin
            rx_reset <= rx_reset_d;
            rx_read  <= rx_read_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rst_cnt <= '0;
        end else if (state != S_ERROR) begin
            rst_cnt <= '0;
        end else if (!rst_done) begin
            rst_cnt <= rst_cnt + RCW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Holdback register and end-of-frame flag
    // -------------------------------------------------------------------------
    // A falling rx_active caused by an error is not a frame end.
    assign eof_fall = rx_active_q && !rx_active && !rx_error;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold        <= '0;
            hold_valid  <= 1'b0;
            eof_pending <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            rx_active_q <= rx_active;
            if (state == S_DISABLED) begin
                hold_valid  <= 1'b0;
                eof_pending <= 1'b0;
            end else if (do_error) begin
                hold_valid  <= 1'b0;
                eof_pending <= 1'b0;
            end else begin
                if (do_capture) begin
                    hold       <= rx_data;
                    hold_valid <= 1'b1;
                end
                if (do_eof) begin
                    hold_valid  <= 1'b0;
                    eof_pending <= 1'b0;
                end
                if (eof_fall) begin
                    eof_pending <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO push source: the decoded actions are mutually exclusive, so at most
    // one entry is offered per cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        push      = do_error || ((do_capture || do_eof) && hold_valid);
        push_data = {2'b00, hold};
        if (do_error) begin
            push_data = {2'b11, rx_data};
        end else if (do_eof) begin
            push_data = {2'b01, hold};
        end
    end

    // -------------------------------------------------------------------------
    // FIFO bookkeeping. A push onto a full FIFO only succeeds if a pop frees
    // a slot in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        pop             = fifo_read && (count != '0);
        push_ok         = push && ((count != CW'(DEPTH)) || pop);
        drop            = push && !push_ok;
        count_after_pop = count - CW'(pop);
        count_n         = count_after_pop + CW'(push_ok);
        rd_ptr_n        = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        // Show-ahead head for the next cycle; when the FIFO is about to be
        // empty apart from this cycle's push, the push data bypasses memory.
        if (count_after_pop == '0) begin
            head_n = push_ok ? push_data : fifo_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            fifo_data  <= head_n;
            fifo_empty <= (count_n == '0);
            fifo_full  <= (count_n == CW'(DEPTH));
        end
    end

    // -------------------------------------------------------------------------
    // Status: a set/latch in the same cycle as clear_status wins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow   <= 1'b0;
            last_error <= '0;
        end else begin
            if (clear_status) begin
                overflow   <= 1'b0;
                last_error <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (do_error) begin
                last_error <= rx_data;
            end
        end
    end

`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
    // -------------------------------------------------------------------------
    // Frame length: counts captured words; loaded at the end-of-frame push.
    // A frame abandoned by an error or by disabling is not reported.
    // -------------------------------------------------------------------------
    logic [9:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt    <= '0;
            frame_length <= '0;
        end else if (state == S_DISABLED || do_error) begin
            frame_cnt <= '0;
        end else if (do_eof && hold_valid) begin
            frame_length <= frame_cnt;
            frame_cnt    <= '0;
        end else if (do_capture && frame_cnt != 10'd1023) begin
            frame_cnt <= frame_cnt + 10'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coax_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_coax_rx_controller
//
// Bench for coax_rx_controller (built with DEPTH=4). A small coax_rx model
// inside the driver tasks answers the read handshake; the expected FIFO
// contents are built frame by frame from the frame rules (every word of a
// frame in order, the last one tagged eof; an error replaces the unfinished
// frame with a single {1,1,code} entry) into a bounded queue.
// -----------------------------------------------------------------------------
module tb_coax_rx_controller;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_reset;
    logic        rx_active;
    logic        rx_error;
    logic [9:0]  rx_data;
    logic        rx_data_available;
    logic        rx_read;
    logic [11:0] fifo_data;
    logic        fifo_read;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;
    logic [9:0]  last_error;
    logic        clear_status;
`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
    logic [9:0]  frame_length;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [9:0]  fw[$];

    coax_rx_controller #(.DEPTH(DEPTH), .RESET_CYCLES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .rx_reset          (rx_reset),
        .rx_active         (rx_active),
        .rx_error          (rx_error),
        .rx_data           (rx_data),
        .rx_data_available (rx_data_available),
        .rx_read           (rx_read),
        .fifo_data         (fifo_data),
        .fifo_read         (fifo_read),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .overflow          (overflow),
        .last_error        (last_error),
        .clear_status      (clear_status)
`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
        ,
        .frame_length      (frame_length)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    task automatic model_push(input logic [11:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    // A completed frame: all words in order, last one tagged eof.
    task automatic model_frame();
        for (int i = 0; i < fw.size(); i++) begin
            model_push({1'b0, (i == fw.size() - 1), fw[i]});
        end
    endtask

    // ---------------- drivers (coax_rx model) ----------------
    // Offers one word, answers the read strobe, and drops data_available on
    // the falling edge of read. Optionally pops the FIFO in the capture cycle.
    task automatic send_word(input logic [9:0] w, input bit pop_now);
        int t;
        int hi;
        wait_neg($urandom_range(2, 4));
        rx_data           = w;
        rx_data_available = 1'b1;
        if (pop_now) fifo_read = 1'b1;
        @(negedge clk);
        fifo_read = 1'b0;
        t = 0;
        while (rx_read !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (rx_read !== 1'b1) begin
            n_err++;
            $display("FAIL read_start word=%h rx_read=%b expected 1", w, rx_read);
        end
        hi = 0;
        while (rx_read === 1'b1 && hi < 10) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != 1) begin
            n_err++;
            $display("FAIL read_pulse_width word=%h width=%0d expected 1", w, hi);
        end
        rx_data_available = 1'b0;
    endtask

    task automatic send_frame(input int n);
        logic [9:0] w;
        fw.delete();
        rx_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 10'($urandom_range(0, 1023));
            fw.push_back(w);
            send_word(w, 1'b0);
        end
        if ($urandom_range(0, 1) == 1) wait_neg($urandom_range(1, 3));
        rx_active = 1'b0;
        wait_neg(8);
        model_frame();
`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
        n_cmp++;
        if (frame_length !== 10'(n)) begin
            n_err++;
            $display("FAIL frame_length got=%0d expected %0d", frame_length, n);
        end
`endif
    endtask

    // Pops every expected entry, checking the head before each pop.
    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (fifo_empty !== 1'b0 || fifo_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL %s_data got=%h empty=%b expected %h", name, fifo_data, fifo_empty, exp_q[0]);
            end
            fifo_read = 1'b1;
            @(negedge clk);
            fifo_read = 1'b0;
            void'(exp_q.pop_front());
            wait_neg($urandom_range(0, 1));
        end
        n_cmp++;
        if (fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL %s_empty got=%b expected 1", name, fifo_empty);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; rx_active = 1'b0; rx_error = 1'b0;
        rx_data = '0; rx_data_available = 1'b0; fifo_read = 1'b0; clear_status = 1'b0;
        wait_neg(4);
        n_cmp++;
        if (rx_reset !== 1'b1 || rx_read !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rx got rx_reset=%b rx_read=%b expected 1 0", rx_reset, rx_read);
        end
        n_cmp++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || overflow !== 1'b0 || last_error !== 10'h0) begin
            n_err++;
            $display("FAIL reset_status got empty=%b full=%b ovf=%b lerr=%h expected 1 0 0 000",
                     fifo_empty, fifo_full, overflow, last_error);
        end
        reset = 1'b1;
        wait_neg(2);
        n_cmp++;
        if (rx_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release rx_reset=%b expected 0", rx_reset);
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] words [3];
        words[0] = 10'h2A5; words[1] = 10'h001; words[2] = 10'h3FF;
        fw.delete();
        rx_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fw.push_back(words[i]);
            send_word(words[i], 1'b0);
        end
        rx_active = 1'b0;
        wait_neg(8);
        model_frame();
`ifdef COAX_RX_CONTROLLER_FRAME_LENGTH_EN
        n_cmp++;
        if (frame_length !== 10'd3) begin
            n_err++;
            $display("FAIL basic_frame_length got=%0d expected 3", frame_length);
        end
`endif
        drain("basic");
    endtask

    task automatic test_error();
        rx_active = 1'b1;
        send_word(10'($urandom_range(0, 1023)), 1'b0);
        wait_neg(3);
        rx_data  = 10'h002;
        rx_error = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rx_reset !== 1'b1 || last_error !== 10'h002) begin
            n_err++;
            $display("FAIL error_entry got rx_reset=%b lerr=%h expected 1 002", rx_reset, last_error);
        end
        @(negedge clk);
        n_cmp++;
        if (rx_reset !== 1'b1) begin
            n_err++;
            $display("FAIL error_reset_2nd rx_reset=%b expected 1", rx_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (rx_reset !== 1'b0) begin
            n_err++;
            $display("FAIL error_reset_end rx_reset=%b expected 0", rx_reset);
        end
        rx_active = 1'b0;
        wait_neg(3);
        rx_error = 1'b0;
        wait_neg(3);
        model_push({2'b11, 10'h002});
        drain("error");
        n_cmp++;
        if (last_error !== 10'h002) begin
            n_err++;
            $display("FAIL error_latched lerr=%h expected 002", last_error);
        end
        send_frame(2);
        drain("after_error");
    endtask

    task automatic test_overflow();
        send_frame(6);
        n_cmp++;
        if (overflow !== exp_ovf || fifo_full !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set got ovf=%b full=%b expected %b 1", overflow, fifo_full, exp_ovf);
        end
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        exp_ovf = 1'b0;
        n_cmp++;
        if (overflow !== exp_ovf || last_error !== 10'h000) begin
            n_err++;
            $display("FAIL overflow_clear got ovf=%b lerr=%h expected 0 000", overflow, last_error);
        end
        drain("overflow");
    endtask

    task automatic test_pop_push_full();
        logic [9:0] w1;
        logic [9:0] w2;
        send_frame(4);
        n_cmp++;
        if (fifo_full !== 1'b1 || overflow !== exp_ovf) begin
            n_err++;
            $display("FAIL full_fill got full=%b ovf=%b expected 1 %b", fifo_full, overflow, exp_ovf);
        end
        w1 = 10'($urandom_range(0, 1023));
        w2 = 10'($urandom_range(0, 1023));
        rx_active = 1'b1;
        send_word(w1, 1'b0);
        n_cmp++;
        if (fifo_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL full_head got=%h expected %h", fifo_data, exp_q[0]);
        end
        // Capture of w2 pushes w1 in the same cycle as the pop.
        send_word(w2, 1'b1);
        void'(exp_q.pop_front());
        model_push({2'b00, w1});
        n_cmp++;
        if (overflow !== 1'b0 || fifo_full !== 1'b1 || exp_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL pop_push_full got ovf=%b full=%b expected 0 1", overflow, fifo_full);
        end
        drain("pop_push");
        rx_active = 1'b0;
        wait_neg(8);
        model_push({2'b01, w2});
        drain("pop_push_eof");
    endtask

    task automatic test_disable();
        rx_active = 1'b1;
        send_word(10'($urandom_range(0, 1023)), 1'b0);
        wait_neg(2);
        enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rx_reset !== 1'b1) begin
            n_err++;
            $display("FAIL disable_reset rx_reset=%b expected 1", rx_reset);
        end
        wait_neg(2);
        rx_active = 1'b0;
        wait_neg(2);
        enable = 1'b1;
        wait_neg(8);
        n_cmp++;
        if (rx_reset !== 1'b0 || fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL disable_drop got rx_reset=%b empty=%b expected 0 1", rx_reset, fifo_empty);
        end
        send_frame(2);
        drain("reenable");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            send_frame($urandom_range(1, 4));
            drain("random");
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            send_frame($urandom_range(1, 2));
            send_frame($urandom_range(1, 2));
            drain("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_error();
        test_overflow();
        test_pop_push_full();
        test_disable();
        test_random_frames();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
